// File: rtl/pipelined_cla_adder_if.sv
// Handshake and data bundle for pipelined_cla_adder.
// The master drives operations in and accepts results; the slave is the adder.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, a, b, carry_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, zero, negative
  );

  modport slave (
    input  in_valid, a, b, carry_in, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, zero, negative
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow
// control. Stage 1 registers the conditioned operands (b inverted and carry
// forced to 1 for subtraction); the two-level lookahead (4-bit groups, then
// a flat lookahead across group generate/propagate) sits between stage 1 and
// stage 2, and stage 2 registers the sum and flags.
module pipelined_cla_adder #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  pipelined_cla_adder_if.slave bus
);

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_width_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of 4 in 4..64");
  end

  localparam int NG = WIDTH / 4;

  // Group generate/propagate for one 4-bit slice, returned as {G, P}.
  function automatic logic [1:0] group_gen_prop(input logic [3:0] g,
                                                input logic [3:0] p);
    logic gen;
    logic prop;
    gen  = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
    prop = &p;
    return {gen, prop};
  endfunction

  // Carries into the four bits of a group, all expressed directly from the
  // group carry-in so no bit waits on its neighbour.
  function automatic logic [3:0] group_carries(input logic [3:0] g,
                                               input logic [3:0] p,
                                               input logic       cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  // Result flags {carry_out, overflow, zero, negative}. Signed overflow is
  // the disagreement between the carry into and the carry out of the MSB.
  function automatic logic [3:0] result_flags(input logic [WIDTH-1:0] s,
                                              input logic             c_msb_in,
                                              input logic             c_msb_out);
    logic ovf;
    logic zro;
    logic neg;
    ovf = c_msb_in ^ c_msb_out;
    zro = (s == '0);
    neg = s[WIDTH-1];
    return {c_msb_out, ovf, zro, neg};
  endfunction

  // Flow control
  logic vld_p1;
  logic vld_p2;
  logic s1_load;
  logic s2_load;

  assign s2_load      = vld_p1 & (~vld_p2 | bus.out_ready);
  assign bus.in_ready = ~vld_p1 | s2_load;
  assign s1_load      = bus.in_valid & bus.in_ready;

  // ---------------- stage 1: conditioned operands ----------------
  logic [WIDTH-1:0] x_p1;
  logic [WIDTH-1:0] y_p1;
  logic             c0_p1;

  // Capture operands only on an accepted transfer; carry_in is ignored for sub.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      x_p1  <= bus.a;
      y_p1  <= bus.sub ? ~bus.b : bus.b;
      c0_p1 <= bus.sub ? 1'b1 : bus.carry_in;
    end
  end

  logic [WIDTH-1:0] g_p1;
  logic [WIDTH-1:0] p_p1;
  logic [NG-1:0]    gg_p1;
  logic [NG-1:0]    gp_p1;
  logic [NG:0]      gc_p1;
  logic [WIDTH:0]   c_p1;
  logic [WIDTH-1:0] s_p1;
  logic [3:0]       flags_p1;

  assign g_p1 = x_p1 & y_p1;
  assign p_p1 = x_p1 ^ y_p1;

  for (genvar k = 0; k < NG; k++) begin : g_group
    assign {gg_p1[k], gp_p1[k]} = group_gen_prop(g_p1[4*k +: 4], p_p1[4*k +: 4]);
    assign c_p1[4*k +: 4]       = group_carries(g_p1[4*k +: 4], p_p1[4*k +: 4],
                                                gc_p1[k]);
  end

  // Second-level lookahead: each group carry is an independent sum of
  // products over lower group G/P terms and c0, so groups never chain.
  always_comb begin : second_level
    logic sop;
    logic pp;
    gc_p1 = '0;
    for (int k = 0; k <= NG; k++) begin
      sop = 1'b0;
      pp  = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        sop = sop | (pp & gg_p1[j]);
        pp  = pp & gp_p1[j];
      end
      gc_p1[k] = sop | (pp & c0_p1);
    end
  end

  assign c_p1[WIDTH] = gc_p1[NG];
  assign s_p1        = p_p1 ^ c_p1[WIDTH-1:0];
  assign flags_p1    = result_flags(s_p1, c_p1[WIDTH-1], c_p1[WIDTH]);

  // ---------------- stage 2: sum and flags ----------------
  logic [WIDTH-1:0] sum_p2;
  logic             co_p2;
  logic             ov_p2;
  logic             z_p2;
  logic             n_p2;

  // Valid bits advance with the handshake; reset drops all in-flight work.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (s1_load) begin
        vld_p1 <= 1'b1;
      end else if (s2_load) begin
        vld_p1 <= 1'b0;
      end
      if (s2_load) begin
        vld_p2 <= 1'b1;
      end else if (bus.out_ready) begin
        vld_p2 <= 1'b0;
      end
    end
  end

  // Result registers load only on a stage advance, so they hold under
  // backpressure; they clear on reset so outputs read zero afterwards.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sum_p2 <= '0;
      co_p2  <= 1'b0;
      ov_p2  <= 1'b0;
      z_p2   <= 1'b0;
      n_p2   <= 1'b0;
    end else if (s2_load) begin
      sum_p2                      <= s_p1;
      {co_p2, ov_p2, z_p2, n_p2}  <= flags_p1;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.sum       = sum_p2;
  assign bus.carry_out = co_p2;
  assign bus.overflow  = ov_p2;
  assign bus.zero      = z_p2;
  assign bus.negative  = n_p2;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder at WIDTH=32: vector table applied
// singly and as streams, backpressure hold, and reset with work in flight.
module tb_pipelined_cla_adder;

  localparam int W  = 32;
  localparam int NV = 12;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
    logic         n;
  } vec_t;

  logic clk;
  logic clr;
  vec_t vecs [NV];
  int   tests;
  int   fails;
  int   q [$];

  pipelined_cla_adder_if #(.WIDTH(W)) bus ();

  pipelined_cla_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input logic sub,
                              input logic [W-1:0] s, input logic co,
                              input logic ov, input logic z, input logic n);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub;
    v.s = s; v.co = co; v.ov = ov; v.z = z; v.n = n;
    return v;
  endfunction

  function automatic logic [63:0] pkt_exp(input vec_t v);
    return {27'd0, 1'b1, v.s, v.co, v.ov, v.z, v.n};
  endfunction

  function automatic logic [63:0] pkt_act();
    return {27'd0, bus.out_valid, bus.sum, bus.carry_out, bus.overflow,
            bus.zero, bus.negative};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i);
    bus.a        = vecs[i].a;
    bus.b        = vecs[i].b;
    bus.carry_in = vecs[i].cin;
    bus.sub      = vecs[i].sub;
  endtask

  // One isolated operation: accept, confirm nothing at +1 cycle, result at +2.
  task automatic apply_single(input int i);
    drive(i);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check($sformatf("accept_ready_%0d", i), {63'd0, bus.in_ready}, 64'd1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    check($sformatf("latency1_%0d", i), {63'd0, bus.out_valid}, 64'd0);
    tick();
    #1;
    check($sformatf("vec_%0d", i), pkt_act(), pkt_exp(vecs[i]));
    tick();
  endtask

  // Stream ops first..first+count-1 under an out_ready/in_valid pattern,
  // scoreboarding results in order.
  // mode 0: always ready; mode 1: out_ready low for cycles 0..5; mode 2: gaps.
  task automatic stream(input int first, input int count, input int mode, input int max_cycles);
    int sent;
    int got;
    int cyc;
    logic hold_sum_ok;
    sent = 0;
    got  = 0;
    cyc  = 0;
    q.delete();
    while (cyc < max_cycles && got < count) begin
      case (mode)
        1:       bus.out_ready = (cyc >= 6);
        2:       bus.out_ready = ((cyc % 3) != 1);
        default: bus.out_ready = 1'b1;
      endcase
      bus.in_valid = (sent < count) && !(mode == 2 && (cyc % 4) == 2);
      if (sent < count) drive(first + sent);
      #1;
      if (mode == 1 && cyc >= 2 && cyc <= 5) begin
        hold_sum_ok = (q.size() > 0);
        check($sformatf("bp_hold_c%0d", cyc), pkt_act(),
              hold_sum_ok ? pkt_exp(vecs[q[0]]) : 64'd0);
      end
      if (mode == 1 && cyc == 5) begin
        check("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
        check("bp_accepted", sent, 2);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check($sformatf("m%0d_unexpected_result", mode), pkt_act(), 64'd0);
        end else begin
          check($sformatf("m%0d_res_%0d", mode, got), pkt_act(), pkt_exp(vecs[q[0]]));
          void'(q.pop_front());
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(first + sent);
        sent++;
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    if (got < count) begin
      check($sformatf("m%0d_timeout_results", mode), got, count);
    end
    if (mode == 0) begin
      check("throughput_cycles", cyc, count + 2);
    end
  endtask

  initial begin
    logic stale;
    tests = 0;
    fails = 0;

    vecs[0]  = mk(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1, 0, 1, 0);
    vecs[1]  = mk(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 0, 1, 0, 1);
    vecs[2]  = mk(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 0, 0, 0, 1);
    vecs[3]  = mk(32'h00000001, 32'h00000002, 1'b1, 1'b0, 32'h00000004, 0, 0, 0, 0);
    vecs[4]  = mk(32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1, 0, 0, 0);
    vecs[5]  = mk(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1, 1, 0, 0);
    vecs[6]  = mk(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1, 1, 1, 0);
    vecs[7]  = mk(32'h12345678, 32'h12345678, 1'b0, 1'b1, 32'h00000000, 1, 0, 1, 0);
    vecs[8]  = mk(32'h0F0F0F0F, 32'h00F0F0F1, 1'b0, 1'b0, 32'h10000000, 0, 0, 0, 0);
    vecs[9]  = mk(32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 0, 0, 0, 0);
    vecs[10] = mk(32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 0, 0, 0, 1);
    vecs[11] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1, 0, 0, 1);

    clr           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.carry_in  = 1'b0;
    bus.sub       = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", pkt_act(), 64'd0);
    clr = 1'b0;
    #1;
    check("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    tick();

    // Table: each vector alone, checking 2-cycle latency
    for (int i = 0; i < NV; i++) begin
      apply_single(i);
    end

    // Back-to-back stream, full throughput
    stream(0, NV, 0, 60);

    // Backpressure: 4 ops with out_ready held low, then released
    stream(0, 4, 1, 40);

    // Irregular in_valid/out_ready pattern
    stream(0, NV, 2, 100);

    // Reset with two operations in flight
    drive(0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    drive(1);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    clr = 1'b1;
    #1;
    check("clr_immediate", pkt_act(), 64'd0);
    tick();
    clr = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("clr_in_ready", {63'd0, bus.in_ready}, 64'd1);
    stale = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.out_valid) stale = 1'b1;
    end
    check("clr_no_stale", {63'd0, stale}, 64'd0);
    apply_single(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
